lfsr_gen: RTL and testbench

- Parametrised successor to the single-width LFSR: configurable width, tap mask, shifts per advance and output word width.
- Adds counted-run and free-run modes, a valid/ready handshake on the pseudo-random output, and all-zero lock-up recovery.
- Sits between the PRNG control logic and pseudo-random consumers such as test-pattern and shuffle logic.

---
 rtl/lfsr_gen.sv | 144 ++++++++++++++
 tb/tb_lfsr_gen.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with counted/free-run modes and a valid/ready output.
// Each advance applies STEPS single shifts and registers the XOR fold of the new state.
module lfsr_gen #(
    parameter int              WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(32'h4000_1064),
    parameter logic [WIDTH-1:0] SEED = WIDTH'(1),
    parameter int              STEPS = 1,
    parameter int              OUT_W = 8,
    parameter int              CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ldVal,
    input  logic             ldLFSR,
    input  logic             step,
    input  logic             runStart,
    input  logic [CNT_W-1:0] runCnt,
    input  logic             freeRun,
    input  logic             psrReady,
    output logic [WIDTH-1:0] lfsrVal,
    output logic [OUT_W-1:0] psrVal,
    output logic             psrValid,
    output logic             busy,
    output logic             lockErr
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FREE
    } fsm_t;

    fsm_t             fsm_q;
    fsm_t             fsm_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] shift_v;
    logic [WIDTH-1:0] adv_v;
    logic [OUT_W-1:0] psr_q;
    logic [OUT_W-1:0] fold_v;
    logic             valid_q;
    logic             busy_q;
    logic             lock_q;
    logic             stall;
    logic             adv;
    logic             load;
    logic             is_zero;

    assign stall = valid_q & ~psrReady;

    // Next state for one advance; an all-zero state recovers to SEED.
    always_comb begin
        shift_v = lfsr_q;
        for (int k = 0; k < STEPS; k++) begin
            shift_v = {shift_v[WIDTH-2:0], ^(shift_v & TAPS)};
        end
        is_zero = (lfsr_q == '0);
        adv_v   = is_zero ? SEED : shift_v;
        fold_v  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fold_v[i % OUT_W] = fold_v[i % OUT_W] ^ adv_v[i];
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        adv   = 1'b0;
        load  = 1'b0;
        if (ldLFSR) begin
            load  = 1'b1;
            fsm_d = IDLE;
            cnt_d = '0;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                    if (runStart && runCnt != '0) begin
                        cnt_d = runCnt;
                        fsm_d = RUN;
                    end else if (freeRun) begin
                        fsm_d = FREE;
                    end else if (step && !stall) begin
                        adv = 1'b1;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        adv   = 1'b1;
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            fsm_d = IDLE;
                        end
                    end
                end
                FREE: begin
                    if (!freeRun) begin
                        fsm_d = IDLE;
                    end else if (!stall) begin
                        adv = 1'b1;
                    end
                end
                default: begin
                    fsm_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q  <= SEED;
            psr_q   <= '0;
            valid_q <= 1'b0;
            lock_q  <= 1'b0;
            busy_q  <= 1'b0;
            fsm_q   <= IDLE;
            cnt_q   <= '0;
        end else begin
            lock_q <= 1'b0;
            if (load) begin
                lfsr_q  <= ldVal;
                valid_q <= 1'b0;
            end else if (adv) begin
                lfsr_q  <= adv_v;
                psr_q   <= fold_v;
                valid_q <= 1'b1;
                lock_q  <= is_zero;
            end else if (psrReady) begin
                valid_q <= 1'b0;
            end
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            busy_q <= (fsm_d != IDLE);
        end
    end

    assign lfsrVal  = lfsr_q;
    assign psrVal   = psr_q;
    assign psrValid = valid_q;
    assign busy     = busy_q;
    assign lockErr  = lock_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: directed scenarios plus random traffic against a
// cycle model built from the shift/fold/handshake rules.
module tb_lfsr_gen;

    localparam logic [31:0] TAPS = 32'h4000_1064;
    localparam logic [31:0] SEED = 32'h1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] ldVal = '0;
    logic        ldLFSR = 1'b0;
    logic        step = 1'b0;
    logic        runStart = 1'b0;
    logic [15:0] runCnt = '0;
    logic        freeRun = 1'b0;
    logic        psrReady = 1'b0;

    logic [31:0] lfsrVal;
    logic [7:0]  psrVal;
    logic        psrValid;
    logic        busy;
    logic        lockErr;

    logic [31:0] lfsrVal8;
    logic [7:0]  psrVal8;
    logic        psrValid8;
    logic        busy8;
    logic        lockErr8;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_lfsr;
    logic [7:0]  m_psr;
    logic        m_valid;
    logic        m_lock;
    int          m_mode;
    int          m_cnt;

    always #5 clk = ~clk;

    lfsr_gen dut (
        .clk(clk), .rst(rst), .ldVal(ldVal), .ldLFSR(ldLFSR),
        .step(step), .runStart(runStart), .runCnt(runCnt),
        .freeRun(freeRun), .psrReady(psrReady),
        .lfsrVal(lfsrVal), .psrVal(psrVal), .psrValid(psrValid),
        .busy(busy), .lockErr(lockErr)
    );

    lfsr_gen #(.STEPS(8)) dut8 (
        .clk(clk), .rst(rst), .ldVal(ldVal), .ldLFSR(ldLFSR),
        .step(step), .runStart(runStart), .runCnt(runCnt),
        .freeRun(freeRun), .psrReady(psrReady),
        .lfsrVal(lfsrVal8), .psrVal(psrVal8), .psrValid(psrValid8),
        .busy(busy8), .lockErr(lockErr8)
    );

    // Reference: mode 0 idle, 1 counted run, 2 free run.
    function automatic logic [31:0] ref_shift(input logic [31:0] s);
        int fb;
        fb = $countones(s & TAPS) % 2;
        return (s << 1) | 32'(fb);
    endfunction

    function automatic logic [7:0] ref_fold(input logic [31:0] s);
        logic [31:0] f;
        f = 0;
        for (int c = 0; c < 32; c += 8) f = f ^ ((s >> c) & 32'hFF);
        return f[7:0];
    endfunction

    task automatic model_cycle();
        bit stall;
        bit adv;
        if (!rst) begin
            m_lfsr = SEED; m_psr = 0; m_valid = 0;
            m_lock = 0; m_mode = 0; m_cnt = 0;
            return;
        end
        stall = m_valid && !psrReady;
        adv = 0;
        m_lock = 0;
        if (ldLFSR) begin
            m_lfsr = ldVal; m_valid = 0; m_mode = 0; m_cnt = 0;
        end else if (m_mode == 0) begin
            if (runStart && runCnt > 0) begin
                m_mode = 1; m_cnt = int'(runCnt);
            end else if (freeRun) m_mode = 2;
            else if (step && !stall) adv = 1;
        end else if (m_mode == 1) begin
            if (!stall) begin
                adv = 1;
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) m_mode = 0;
            end
        end else begin
            if (!freeRun) m_mode = 0;
            else if (!stall) adv = 1;
        end
        if (adv) begin
            if (m_lfsr == 0) begin
                m_lfsr = SEED; m_lock = 1;
            end else m_lfsr = ref_shift(m_lfsr);
            m_psr = ref_fold(m_lfsr);
            m_valid = 1;
        end else if (!ldLFSR && psrReady) m_valid = 0;
    endtask

    task automatic tick();
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ldLFSR = 0; step = 0; runStart = 0; runCnt = 0; freeRun = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        tick();
        rst = 1;
        n_cmp++;
        if (lfsrVal !== 32'h1 || psrVal !== 8'h0 || psrValid !== 1'b0 ||
            busy !== 1'b0 || lockErr !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: got lfsr=%h psr=%h v=%b b=%b l=%b, want 1/0/0/0/0",
                     lfsrVal, psrVal, psrValid, busy, lockErr);
        end
    endtask

    task automatic test_step();
        logic [31:0] exp [3];
        exp[0] = 32'h2; exp[1] = 32'h4; exp[2] = 32'h9;
        test_reset();
        psrReady = 1;
        step = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (lfsrVal !== exp[i]) begin
                n_bad++;
                $display("FAIL step%0d: lfsr=%h want %h", i, lfsrVal, exp[i]);
            end
        end
        step = 0;
        n_cmp++;
        if (psrVal !== 8'h09 || psrValid !== 1'b1) begin
            n_bad++;
            $display("FAIL step_psr: psr=%h v=%b want 09/1", psrVal, psrValid);
        end
    endtask

    task automatic test_steps8();
        test_reset();
        psrReady = 1;
        step = 1;
        tick();
        step = 0;
        n_cmp++;
        if (lfsrVal8 !== 32'h122 || psrVal8 !== 8'h23 || psrValid8 !== 1'b1) begin
            n_bad++;
            $display("FAIL steps8: lfsr=%h psr=%h v=%b want 122/23/1",
                     lfsrVal8, psrVal8, psrValid8);
        end
    endtask

    task automatic test_lockup();
        psrReady = 1;
        ldLFSR = 1; ldVal = 0;
        tick();
        ldLFSR = 0;
        n_cmp++;
        if (lfsrVal !== 32'h0 || psrValid !== 1'b0) begin
            n_bad++;
            $display("FAIL load_zero: lfsr=%h v=%b want 0/0", lfsrVal, psrValid);
        end
        step = 1;
        tick();
        step = 0;
        n_cmp++;
        if (lfsrVal !== SEED || lockErr !== 1'b1 || psrValid !== 1'b1 ||
            psrVal !== 8'h01) begin
            n_bad++;
            $display("FAIL lockup: lfsr=%h l=%b v=%b psr=%h want 1/1/1/01",
                     lfsrVal, lockErr, psrValid, psrVal);
        end
        tick();
        n_cmp++;
        if (lockErr !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_pulse: lockErr=%b want 0", lockErr);
        end
    endtask

    task automatic test_run(input bit with_stall);
        int busy_n;
        int adv_n;
        int k;
        logic [31:0] prev;
        logic [7:0]  prev_psr;
        test_reset();
        psrReady = 1;
        runStart = 1; runCnt = 5;
        tick();
        runStart = 0; runCnt = 0;
        busy_n = busy ? 1 : 0;
        adv_n = 0;
        k = 0;
        while (busy && k < 20) begin
            k++;
            psrReady = !(with_stall && k >= 2 && k <= 4);
            prev = lfsrVal;
            prev_psr = psrVal;
            tick();
            if (lfsrVal !== prev) adv_n++;
            if (with_stall && k >= 2 && k <= 4) begin
                n_cmp++;
                if (lfsrVal !== prev || psrVal !== prev_psr) begin
                    n_bad++;
                    $display("FAIL stall_hold%0d: lfsr=%h psr=%h want %h/%h",
                             k, lfsrVal, psrVal, prev, prev_psr);
                end
            end
            if (busy) busy_n++;
        end
        psrReady = 1;
        n_cmp++;
        if (k >= 20) begin
            n_bad++;
            $display("FAIL run_timeout: busy still %b after %0d cycles", busy, k);
        end
        n_cmp++;
        if (busy_n !== (with_stall ? 8 : 5) || adv_n !== 5) begin
            n_bad++;
            $display("FAIL run_len: busy_cycles=%0d advances=%0d want %0d/5",
                     busy_n, adv_n, with_stall ? 8 : 5);
        end
        n_cmp++;
        if (lfsrVal !== 32'h24 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL run_end: lfsr=%h busy=%b want 24/0", lfsrVal, busy);
        end
    endtask

    task automatic test_free_load();
        test_reset();
        psrReady = 1;
        freeRun = 1;
        tick();
        tick();
        ldLFSR = 1; ldVal = 32'hDEAD_BEEF;
        tick();
        ldLFSR = 0;
        n_cmp++;
        if (lfsrVal !== 32'hDEAD_BEEF || psrValid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL free_load: lfsr=%h v=%b busy=%b want deadbeef/0/0",
                     lfsrVal, psrValid, busy);
        end
        tick();
        freeRun = 0;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL free_exit: busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_in_run();
        psrReady = 1;
        runStart = 1; runCnt = 5;
        tick();
        runStart = 0; runCnt = 0;
        tick();
        rst = 0;
        tick();
        rst = 1;
        n_cmp++;
        if (lfsrVal !== 32'h1 || psrVal !== 8'h0 || psrValid !== 1'b0 ||
            busy !== 1'b0 || lockErr !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_in_run: lfsr=%h psr=%h v=%b b=%b l=%b",
                     lfsrVal, psrVal, psrValid, busy, lockErr);
        end
    endtask

    task automatic test_random();
        int shown;
        shown = 0;
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 199) != 0);
            ldLFSR = ($urandom_range(0, 29) == 0);
            ldVal = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
            runStart = ($urandom_range(0, 14) == 0);
            runCnt = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 9) == 0) freeRun = ~freeRun;
            step = 1'($urandom);
            psrReady = ($urandom_range(0, 3) != 0);
            tick();
            n_cmp++;
            if (lfsrVal !== m_lfsr || psrVal !== m_psr || psrValid !== m_valid ||
                busy !== (m_mode != 0) || lockErr !== m_lock) begin
                n_bad++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL random%0d: got %h/%h/%b/%b/%b want %h/%h/%b/%b/%b",
                             c, lfsrVal, psrVal, psrValid, busy, lockErr,
                             m_lfsr, m_psr, m_valid, m_mode != 0, m_lock);
                end
            end
        end
        rst = 1;
        idle_inputs();
    endtask

    initial begin
        #2;
        test_reset();
        test_step();
        test_steps8();
        test_lockup();
        test_run(0);
        test_run(1);
        test_free_load();
        test_reset_in_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
